// File: rtl/vga_frame_reader.sv
// vga_frame_reader: issues fixed-length SDRAM burst reads for a display frame
// and forwards the returned beats to vga_interface, one cycle after they arrive.
// Optional macro VGA_RD_PINGPONG_EN: double-buffered frames. On resync the read
// bank flips to the other buffer once the writer has reported a finished frame.
module vga_frame_reader #(
   parameter int unsigned       ADDR_W     = 24,
   parameter int unsigned       BURST_LEN  = 4,
   parameter int unsigned       FRAME_PIX  = 921600,
   parameter logic [ADDR_W-1:0] BANK0_BASE = ADDR_W'(24'h000000),
   parameter logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(24'h100000)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              frame_sync,
   input  logic              rdy,
   input  logic              wr_frame_done,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_ack,
   input  logic [15:0]       rd_data,
   input  logic              rd_data_vld,
   output logic [15:0]       dout,
   output logic              dout_vld,
   output logic              busy
);

   localparam int unsigned       BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BEAT_W-1:0] BEAT_LAST  = BEAT_W'(BURST_LEN - 1);
   localparam logic [ADDR_W-1:0] BURST_INC  = ADDR_W'(BURST_LEN);
   localparam logic [ADDR_W-1:0] FRAME_SPAN = ADDR_W'(FRAME_PIX);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic                resync_q, resync_d;
   logic                rd_req_q, rd_req_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic [15:0]         dout_q, dout_d;
   logic                dout_vld_q, dout_vld_d;
   logic                busy_q, busy_d;

   logic [ADDR_W-1:0]   base_c;
   logic [ADDR_W-1:0]   svc_base_c;
   logic [ADDR_W-1:0]   next_addr_c;
   logic                wrap_c;
   logic                service_c;

   // A pending resync is serviced in IDLE, taking that cycle instead of a request
   assign service_c   = (state_q == ST_IDLE) && resync_q;
   assign next_addr_c = cur_addr_q + BURST_INC;
   assign wrap_c      = ((next_addr_c - base_c) == FRAME_SPAN);

`ifdef VGA_RD_PINGPONG_EN
   logic bank_q, bank_d;
   logic wr_ready_q, wr_ready_d;

   // Bank select: flip buffers at resync only after the writer finished a frame
   always_comb begin
      bank_d     = bank_q;
      wr_ready_d = wr_ready_q | wr_frame_done;
      if (service_c && wr_ready_q) begin
         bank_d     = ~bank_q;
         wr_ready_d = wr_frame_done;
      end
   end

   // Bank state registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bank_q     <= 1'b0;
         wr_ready_q <= 1'b0;
      end else begin
         bank_q     <= bank_d;
         wr_ready_q <= wr_ready_d;
      end
   end

   assign base_c     = bank_q ? BANK1_BASE : BANK0_BASE;
   assign svc_base_c = bank_d ? BANK1_BASE : BANK0_BASE;
`else
   logic unused_cfg_c;

   assign base_c       = BANK0_BASE;
   assign svc_base_c   = BANK0_BASE;
   assign unused_cfg_c = ^{wr_frame_done, BANK1_BASE};
`endif

   // Next-state, address, beat and output logic
   always_comb begin
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      beat_d     = beat_q;
      resync_d   = resync_q | frame_sync;
      rd_addr_d  = rd_addr_q;
      dout_d     = dout_q;
      dout_vld_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (resync_q) begin
               cur_addr_d = svc_base_c;
               resync_d   = frame_sync;
            end else if (rdy && !frame_sync) begin
               state_d   = ST_REQ;
               rd_addr_d = cur_addr_q;
            end
         end
         ST_REQ: begin
            if (rd_ack) begin
               state_d = ST_DATA;
               beat_d  = '0;
            end
         end
         ST_DATA: begin
            if (rd_data_vld) begin
               dout_d     = rd_data;
               dout_vld_d = 1'b1;
               beat_d     = beat_q + BEAT_W'(1);
               if (beat_q == BEAT_LAST) begin
                  beat_d  = '0;
                  state_d = ST_IDLE;
                  // A coincident frame_sync discards the increment; resync follows
                  if (!frame_sync) begin
                     cur_addr_d = wrap_c ? base_c : next_addr_c;
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      rd_req_d = (state_d == ST_REQ);
      busy_d   = (state_d != ST_IDLE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cur_addr_q <= BANK0_BASE;
         beat_q     <= '0;
         resync_q   <= 1'b0;
         rd_req_q   <= 1'b0;
         rd_addr_q  <= BANK0_BASE;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_addr_q <= cur_addr_d;
         beat_q     <= beat_d;
         resync_q   <= resync_d;
         rd_req_q   <= rd_req_d;
         rd_addr_q  <= rd_addr_d;
         dout_q     <= dout_d;
         dout_vld_q <= dout_vld_d;
         busy_q     <= busy_d;
      end
   end

   assign rd_req   = rd_req_q;
   assign rd_addr  = rd_addr_q;
   assign dout     = dout_q;
   assign dout_vld = dout_vld_q;
   assign busy     = busy_q;

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Read-side sequencer between the SDRAM controller read port and `vga_interface`. It issues fixed-length burst reads for a 1280×720 RGB565 frame whenever the display FIFO requests data, and forwards returned pixels as a 16-bit stream on `dout`/`dout_vld`. The block resynchronises its address to the frame base on each frame-sync pulse, so display and memory frames stay aligned. Everything runs in the 75 MHz pixel clock domain.

## Interface
- `ADDR_W`, 24, SDRAM word-address width
- `BURST_LEN`, 4, words per read burst (power of two, 2..8)
- `FRAME_PIX`, 921600, words per frame; must be a multiple of `BURST_LEN`
- `BANK0_BASE`, 24'h000000, frame buffer 0 base address
- `BANK1_BASE`, 24'h100000, frame buffer 1 base address (used only with `PINGPONG_EN`)

- `clk`  in  1  pixel clock, 75 MHz; the block's only clock
- `rst_n`  in  1  reset, **synchronous, active-low**
- `frame_sync`  in  1  one-cycle pulse marking the start of a new display frame
- `rdy`  in  1  level request for more data (from `vga_interface`)
- `wr_frame_done`  in  1  one-cycle pulse when the writer completes a frame (`PINGPONG_EN` only)
- `rd_req`  out  1  burst read request to the SDRAM controller
- `rd_addr`  out  ADDR_W  burst start address; stable while `rd_req`=1
- `rd_ack`  in  1  controller accepted the request
- `rd_data`  in  16  read data beat
- `rd_data_vld`  in  1  `rd_data` valid
- `dout`  out  16  pixel to `vga_interface` `din`
- `dout_vld`  out  1  pixel valid, drives `din_vld`
- `busy`  out  1  high in REQ or DATA

## Operation
- FSM with states IDLE, REQ and DATA; reset state is IDLE.
  - IDLE → REQ when `rdy`=1 and no resync is pending.
  - REQ → DATA on `rd_ack`=1.
  - DATA → IDLE on the final beat, when the beat counter equals `BURST_LEN-1` and `rd_data_vld`=1.
- Address counter `cur_addr` (ADDR_W bits):
  - After the final beat, `cur_addr` += `BURST_LEN`.
  - If the new offset from the current base equals `FRAME_PIX`, `cur_addr` wraps to the current base instead.
- Beat counter runs 0..`BURST_LEN-1` and counts only `rd_data_vld` beats in DATA. `rd_data_vld` outside DATA is ignored and not forwarded.
- `frame_sync` sets a sticky `resync` flag.
  - The flag is serviced only in IDLE: `cur_addr` ← base, then the flag is cleared.
  - While `resync` is set, IDLE does not enter REQ; servicing takes one cycle.
  - A `frame_sync` during REQ or DATA does not abort the burst. The burst completes and all its beats are forwarded.
- Simultaneous `frame_sync` and final beat: the address increment is discarded and the resync wins.
- `rdy` is sampled only in IDLE. Its deassertion mid-burst has no effect.
- Consumer constraint: the `vga_interface` FIFO (depth 16, `rdy` deasserts at usedw ≥ 12) absorbs one worst-case burst for `BURST_LEN` ≤ 4.

## Timing
- Reset values: `rd_req`=0, `rd_addr`=`BANK0_BASE`, `dout`=0, `dout_vld`=0, `busy`=0. Internally: `cur_addr`=`BANK0_BASE`, beats=0, `resync`=0, bank=0.
- `rd_req` is registered and goes high the cycle after IDLE samples `rdy`=1.
  - It holds high, with `rd_addr` stable, until the cycle after `rd_ack`.
  - `rd_ack` may arrive in the first `rd_req` cycle.
- Data path latency is 1 cycle: `dout`/`dout_vld` is `rd_data`/`rd_data_vld` registered (gated by DATA).
- Minimum burst-to-burst spacing is 1 IDLE cycle.
- Reset asserted mid-burst returns the block to reset values on the next edge. Pending controller beats after reset are ignored.

## Configuration
- `VGA_RD_PINGPONG_EN` defined:
  - A `wr_ready` flag is set by `wr_frame_done`.
  - On resync servicing with `wr_ready`=1, the bank toggles, `cur_addr` ← the new bank base, and `wr_ready` is cleared.
  - With `wr_ready`=0, the same bank is re-read.
- Undefined: `wr_frame_done` is ignored, the base is always `BANK0_BASE`, and the bank logic is not synthesised.

## Test plan
- Reset, then `rdy`=1 with `rd_ack` one cycle after `rd_req` and 4 beats returned → `rd_addr`=0, then 4, then 8. `dout` equals `rd_data` delayed by 1 cycle; `busy` is low between bursts.
- `rd_ack` withheld for 10 cycles → `rd_req` and `rd_addr` are held stable for all 10 cycles; no `dout_vld`.
- Preload `cur_addr` = `FRAME_PIX-4` and complete one burst → the next `rd_addr`=0 (wrap).
- `frame_sync` during beat 2 at `cur_addr`=400 → beats 2–3 are still forwarded; the next `rd_addr`=0. `frame_sync` coincident with the final beat → the next `rd_addr`=0.
- With `VGA_RD_PINGPONG_EN`: `wr_frame_done` then `frame_sync` → the next `rd_addr`=24'h100000. A second `frame_sync` without `wr_frame_done` → the next `rd_addr`=24'h100000 again.
- Stray `rd_data_vld` in IDLE → `dout_vld` stays 0. Reset asserted in DATA → all outputs return to reset values the next cycle.
